// File: rtl/ieee_converter_pipe.sv
// rtl/ieee_converter_pipe.sv - 3-stage fixed-point to IEEE-754 single converter, RNE rounding, valid/ready
module ieee_converter_pipe #(
  parameter int INT_LEN   = 16,
  parameter int FRA_LEN   = 16,
  parameter int TWOS_COMP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INT_LEN+FRA_LEN-1:0] in_data,
  input  logic                       in_sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_ieee,
  output logic                       out_inexact
);

  localparam int W = INT_LEN + FRA_LEN;

  logic         w_en;
  logic         r_s1_valid;
  logic         r_s1_sign;
  logic [W-1:0] r_s1_mag;
  logic         r_s2_valid;
  logic         r_s2_sign;
  logic [W-1:0] r_s2_mag;
  logic [6:0]   r_s2_p;
  logic [7:0]   r_s2_exp;
  logic         r_s3_valid;
  logic [31:0]  r_s3_ieee;
  logic         r_s3_inexact;

  logic         w_s1_sign;
  logic [W-1:0] w_s1_mag;
  logic [6:0]   w_p;
  logic [W-1:0] w_norm;
  logic [64:0]  w_frac;
  logic         w_nonzero;
  logic         w_g;
  logic         w_s;
  logic         w_up;
  logic [23:0]  w_mant_rnd;
  logic [7:0]   w_exp;
  logic [31:0]  w_ieee;
  logic         w_inexact;

  assign w_en        = ~r_s3_valid | out_ready;
  assign in_ready    = w_en;
  assign out_valid   = r_s3_valid;
  assign out_ieee    = r_s3_ieee;
  assign out_inexact = r_s3_inexact;

  // Negating the most-negative word wraps back to 2^(W-1), which is the exact magnitude.
  always_comb begin
    if (TWOS_COMP != 0) begin
      w_s1_sign = in_data[W-1];
      w_s1_mag  = in_data[W-1] ? ((~in_data) + W'(1)) : in_data;
    end else begin
      w_s1_sign = in_sign;
      w_s1_mag  = in_data;
    end
  end

  always_comb begin
    w_p = '0;
    for (int i = 0; i < W; i++) begin
      if (r_s1_mag[i]) w_p = 7'(i);
    end
  end

  // Leading one moved to the top; everything below it is the fraction, padded out to 64 bits.
  always_comb begin
    w_norm     = r_s2_mag << (7'(W - 1) - r_s2_p);
    w_frac     = {w_norm, {(65 - W){1'b0}}};
    w_nonzero  = w_frac[64];
    w_g        = w_frac[40];
    w_s        = |w_frac[39:0];
    w_up       = w_g & (w_s | w_frac[41]);
    w_mant_rnd = {1'b0, w_frac[63:41]} + 24'(w_up);
    w_exp      = r_s2_exp + 8'(w_mant_rnd[23]);
    w_ieee     = w_nonzero ? {r_s2_sign, w_exp, w_mant_rnd[22:0]} : 32'h0;
    w_inexact  = w_nonzero & (w_g | w_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_s3_ieee    <= 32'h0;
      r_s3_inexact <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_s1_sign;
      r_s1_mag   <= w_s1_mag;
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_mag   <= r_s1_mag;
      r_s2_p     <= w_p;
      r_s2_exp   <= 8'(w_p) - 8'(FRA_LEN) + 8'd127;
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_ieee    <= w_ieee;
        r_s3_inexact <= w_inexact;
      end
    end
  end

endmodule

// File: tb/tb_ieee_converter_pipe.sv
// tb/tb_ieee_converter_pipe.sv - self-checking bench for ieee_converter_pipe
module tb_ieee_converter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ieee;
  logic        out_inexact;

  logic        sm_in_valid;
  logic        sm_in_ready;
  logic [31:0] sm_in_data;
  logic        sm_in_sign;
  logic        sm_out_valid;
  logic        sm_out_ready;
  logic [31:0] sm_out_ieee;
  logic        sm_out_inexact;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  int          n_out;
  logic        stall_prev;
  logic [32:0] held;

  always #5 clk = ~clk;

  ieee_converter_pipe #(.INT_LEN(16), .FRA_LEN(16), .TWOS_COMP(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready), .out_ieee(out_ieee),
    .out_inexact(out_inexact)
  );

  ieee_converter_pipe #(.INT_LEN(16), .FRA_LEN(16), .TWOS_COMP(0)) u_dut_sm (
    .clk(clk), .rst(rst), .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_data(sm_in_data),
    .in_sign(sm_in_sign), .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_ieee(sm_out_ieee),
    .out_inexact(sm_out_inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer magnitude, divide by a power of two, round half to even.
  function automatic logic [32:0] ref_conv(input logic [31:0] d, input logic sgn, input bit twos);
    logic [63:0] mag, q, rem, half;
    logic        neg, inex, up;
    int          p, sh;
    logic [7:0]  e;
    mag = {32'h0, d};
    if (twos) begin
      neg = d[31];
      if (neg) mag = 64'h1_0000_0000 - mag;
    end else begin
      neg = sgn;
    end
    if (mag == 64'd0) return 33'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (((mag >> i) & 64'd1) != 64'd0) p = i;
    inex = 1'b0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && q[0]);
      q    = q + {63'd0, up};
      inex = (rem != 64'd0);
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    e = 8'(p - 16 + 127);
    return {inex, neg, e, q[22:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = $urandom;
      1: r = $urandom_range(0, 255);
      2: r = 32'h8000_0000 | $urandom_range(0, 3);
      3: r = 32'h0100_0000 | $urandom_range(0, 7);
      4: r = $urandom >> $urandom_range(0, 31);
      default: r = 32'h0 - $urandom_range(0, 100000);
    endcase
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sm_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  task automatic directed(input logic [31:0] d, input logic [31:0] e_ieee, input logic e_inex, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check({tag, "_ieee"}, {32'h0, out_ieee}, {32'h0, e_ieee});
    check({tag, "_inexact"}, {63'h0, out_inexact}, {63'h0, e_inex});
  endtask

  task automatic sm_directed(input logic [31:0] d, input logic s, input logic [32:0] e, input string tag);
    int n;
    @(negedge clk);
    sm_in_valid = 1'b1; sm_in_data = d; sm_in_sign = s;
    @(posedge clk); #1;
    sm_in_valid = 1'b0;
    n = 1;
    while (!sm_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check(tag, {31'h0, sm_out_inexact, sm_out_ieee}, {31'h0, e});
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, output logic accepted);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("hold_valid", {63'h0, out_valid}, 64'd1);
      check("hold_data", {31'h0, out_inexact, out_ieee}, {31'h0, held});
    end
    if (out_valid && !ordy) check("in_ready_stall", {63'h0, in_ready}, 64'd0);
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("unexpected_out", {32'h0, out_ieee}, 64'hDEAD);
      else check("stream_data", {31'h0, out_inexact, out_ieee}, {31'h0, exp_q.pop_front()});
      n_out++;
    end
    accepted = v & in_ready;
    if (accepted) exp_q.push_back(ref_conv(d, 1'b0, 1'b1));
    stall_prev = out_valid & ~ordy;
    held = {out_inexact, out_ieee};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   sent;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sign = 1'b0; out_ready = 1'b0;
    sm_in_valid = 1'b0; sm_in_data = '0; sm_in_sign = 1'b0; sm_out_ready = 1'b1;
    stall_prev = 1'b0; held = '0; n_out = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_out_ieee", {32'h0, out_ieee}, 64'd0);
    check("rst_out_inexact", {63'h0, out_inexact}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);

    directed(32'h0001_8000, 32'h3FC0_0000, 1'b0, "pos_1p5");
    directed(32'hFFFE_8000, 32'hBFC0_0000, 1'b0, "neg_1p5");
    directed(32'h8000_0000, 32'hC700_0000, 1'b0, "most_neg");
    directed(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
    directed(32'h0100_0001, 32'h4380_0000, 1'b1, "rne_tie_even");
    directed(32'h0100_0002, 32'h4380_0001, 1'b0, "exact_lsb");
    directed(32'h0100_0003, 32'h4380_0002, 1'b1, "rne_tie_odd_up");
    directed(32'h01FF_FFFF, 32'h4400_0000, 1'b1, "mant_carry");
    directed(32'h0000_0001, 32'h3780_0000, 1'b0, "min_pos");
    directed(32'h7FFF_FFFF, 32'h4700_0000, 1'b1, "max_pos");

    sm_directed(32'h0001_8000, 1'b1, {1'b0, 32'hBFC0_0000}, "sm_neg_1p5");
    sm_directed(32'h0000_0000, 1'b1, 33'h0, "sm_neg_zero");
    sm_directed(32'hFFFF_FFFF, 1'b0, {1'b1, 32'h4780_0000}, "sm_all_ones");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      logic        s;
      d = rand_word();
      s = 1'($urandom_range(0, 1));
      sm_directed(d, s, ref_conv(d, s, 1'b0), "sm_rand");
    end

    apply_reset();
    n_out = 0; sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() != 0); c++) begin
      cycle(sent < 8, rand_word(), !(c >= 4 && c < 9), acc);
      if (acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'd8);
    check("bp_received", 64'(n_out), 64'd8);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 9) < 7), acc);
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cycle(1'b0, 32'h0, 1'b1, acc);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    cycle(1'b1, 32'h0001_0000, 1'b1, acc);
    cycle(1'b1, 32'h0002_0000, 1'b1, acc);
    cycle(1'b1, 32'h0003_0000, 1'b1, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("midrst_no_emit", {63'h0, out_valid}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
